spatz_vrf_banked: RTL and testbench



---
 rtl/spatz_pkg.sv | 36 +++
 rtl/spatz_vrf_bank.sv | 73 +++++++
 rtl/spatz_vrf_banked.sv | 232 +++++++++++++++++++++++
 tb/tb_spatz_vrf_banked.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatz_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spatz_pkg
// Description : Shared constants and types for the banked Spatz vector
//               register file. Holds the requester port slot assignments,
//               the default stall counter type and a small width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spatz_pkg;

  // Read requester slots
  localparam int unsigned VFU_RD_VS1 = 0;
  localparam int unsigned VFU_RD_VS2 = 1;
  localparam int unsigned VFU_RD_VD  = 2;
  localparam int unsigned VLSU_RD    = 3;
  localparam int unsigned VSLDU_RD   = 4;

  // Write requester slots
  localparam int unsigned VFU_WR     = 0;
  localparam int unsigned VLSU_WR    = 1;
  localparam int unsigned VSLDU_WR   = 2;

  // Stall counter for the default aging threshold; the counter only needs
  // to reach MaxStall, never beyond, so $clog2(MaxStall+1) bits suffice.
  localparam int unsigned MAX_STALL_DEFAULT = 4;
  localparam int unsigned STALL_CNT_W       = $clog2(MAX_STALL_DEFAULT + 1);
  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Index width that never collapses to zero bits for single-entry arrays.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spatz_vrf_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spatz_vrf_bank
// Description : One flip-flop register file bank. One byte-enabled write
//               port, NrRdPorts read ports with registered read data.
//               Optional macro SPATZ_VRF_WBYPASS_EN: a read and a write to
//               the same row in the same cycle return the merged new data
//               instead of the pre-write data.
// Ports       : clk, rst         - clock, async active-high reset
//               we/waddr/wdata/wbe - write strobe, row, data, byte enables
//               re/raddr          - per read port strobe and row
//               rdata             - registered read data (holds when re=0)
// Revision    : 1.0 - initial release
// ============================================================================
module spatz_vrf_bank
  import spatz_pkg::*;
#(
  parameter int unsigned NrRows    = 32,
  parameter int unsigned NrRdPorts = 3,
  parameter int unsigned DataWidth = 256,
  parameter int unsigned RowW      = clog2_min1(NrRows)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 we,
  input  logic [RowW-1:0]                      waddr,
  input  logic [DataWidth-1:0]                 wdata,
  input  logic [DataWidth/8-1:0]               wbe,
  input  logic [NrRdPorts-1:0]                 re,
  input  logic [NrRdPorts-1:0][RowW-1:0]       raddr,
  output logic [NrRdPorts-1:0][DataWidth-1:0]  rdata
);

  localparam int unsigned BeW = DataWidth / 8;

  logic [DataWidth-1:0] mem [NrRows];
  logic [DataWidth-1:0] merged;

  // New contents of the written row: enabled bytes from wdata, others kept.
  always_comb begin
    merged = mem[waddr];
    for (int unsigned k = 0; k < BeW; k++) begin
      if (wbe[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NrRows; r++) mem[r] <= '0;
    end else if (we) begin
      mem[waddr] <= merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      for (int unsigned j = 0; j < NrRdPorts; j++) begin
        if (re[j]) begin
`ifdef SPATZ_VRF_WBYPASS_EN
          rdata[j] <= (we && (waddr == raddr[j])) ? merged : mem[raddr[j]];
`else
          rdata[j] <= mem[raddr[j]];
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spatz_vrf_banked.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spatz_vrf_banked
// Description : Multi-banked vector register file. Per-bank write
//               arbitration and per bank x read-group arbitration with
//               age-boosted priority (a port denied MaxStall times in a row
//               beats non-aged ports). Read data returns one cycle after
//               grant and holds while rvalid_o is low.
//               Optional macro SPATZ_VRF_WBYPASS_EN enables same-cycle
//               write-to-read bypass inside the banks.
// Ports       : clk_i, rst_i              - clock, async active-high reset
//               waddr_i/wdata_i/wbe_i/we_i - write requests
//               wgnt_o                     - write grant (commits this edge)
//               raddr_i/re_i               - read requests
//               rgnt_o                     - read grant
//               rdata_o/rvalid_o           - read response
// Revision    : 1.0 - initial release
// ============================================================================
module spatz_vrf_banked
  import spatz_pkg::*;
#(
  parameter int unsigned NrBanks       = 4,
  parameter int unsigned NrReadPorts   = 5,
  parameter int unsigned NrWritePorts  = 3,
  parameter int unsigned NrBankRdPorts = 3,
  parameter int unsigned NrWords       = 128,
  parameter int unsigned DataWidth     = 256,
  parameter int unsigned MaxStall      = MAX_STALL_DEFAULT,
  parameter int unsigned AddrWidth     = $clog2(NrWords)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NrWritePorts-1:0][AddrWidth-1:0] waddr_i,
  input  logic [NrWritePorts-1:0][DataWidth-1:0] wdata_i,
  input  logic [NrWritePorts-1:0][DataWidth/8-1:0] wbe_i,
  input  logic [NrWritePorts-1:0]                we_i,
  output logic [NrWritePorts-1:0]                wgnt_o,
  input  logic [NrReadPorts-1:0][AddrWidth-1:0]  raddr_i,
  input  logic [NrReadPorts-1:0]                 re_i,
  output logic [NrReadPorts-1:0]                 rgnt_o,
  output logic [NrReadPorts-1:0][DataWidth-1:0]  rdata_o,
  output logic [NrReadPorts-1:0]                 rvalid_o
);

  localparam int unsigned NrRows = NrWords / NrBanks;
  localparam int unsigned RowW   = clog2_min1(NrRows);
  localparam int unsigned StallW = $clog2(MaxStall + 1);
  localparam int unsigned BeW    = DataWidth / 8;

  // Banks are power-of-two interleaved: low bits pick the bank.
  function automatic int unsigned bank_of(input logic [AddrWidth-1:0] a);
    return 32'(a) % NrBanks;
  endfunction

  function automatic logic [RowW-1:0] row_of(input logic [AddrWidth-1:0] a);
    return RowW'(32'(a) / NrBanks);
  endfunction

  logic [NrWritePorts-1:0][StallW-1:0] wstall_q;
  logic [NrReadPorts-1:0][StallW-1:0]  rstall_q;
  logic [NrWritePorts-1:0]             waged;
  logic [NrReadPorts-1:0]              raged;

  // One-hot grant matrices: which requester won each contention set.
  logic [NrBanks-1:0][NrWritePorts-1:0]                    wgnt_mat;
  logic [NrBanks-1:0][NrBankRdPorts-1:0][NrReadPorts-1:0]  rgnt_mat;

  logic [NrBanks-1:0]                                      bank_we;
  logic [NrBanks-1:0][RowW-1:0]                            bank_waddr;
  logic [NrBanks-1:0][DataWidth-1:0]                       bank_wdata;
  logic [NrBanks-1:0][BeW-1:0]                             bank_wbe;
  logic [NrBanks-1:0][NrBankRdPorts-1:0]                   bank_re;
  logic [NrBanks-1:0][NrBankRdPorts-1:0][RowW-1:0]         bank_raddr;
  logic [NrBanks-1:0][NrBankRdPorts-1:0][DataWidth-1:0]    bank_rdata;

  logic [NrReadPorts-1:0][NrBanks-1:0]   rbank_oh;
  logic [NrReadPorts-1:0][NrBanks-1:0]   rbank_oh_q;
  logic [NrReadPorts-1:0]                rvalid_q;
  logic [NrReadPorts-1:0][DataWidth-1:0] hold_q;

  always_comb begin
    for (int unsigned p = 0; p < NrWritePorts; p++)
      waged[p] = (wstall_q[p] == StallW'(MaxStall));
    for (int unsigned i = 0; i < NrReadPorts; i++)
      raged[i] = (rstall_q[i] == StallW'(MaxStall));
  end

  // Two passes per set: first pick the lowest aged requester, otherwise the
  // lowest requester. Grants are forced low during reset.
  always_comb begin
    logic found;
    found    = 1'b0;
    wgnt_mat = '0;
    rgnt_mat = '0;
    if (!rst_i) begin
      for (int unsigned b = 0; b < NrBanks; b++) begin
        found = 1'b0;
        for (int unsigned p = 0; p < NrWritePorts; p++) begin
          if (!found && we_i[p] && waged[p] && (bank_of(waddr_i[p]) == b)) begin
            wgnt_mat[b][p] = 1'b1;
            found          = 1'b1;
          end
        end
        for (int unsigned p = 0; p < NrWritePorts; p++) begin
          if (!found && we_i[p] && (bank_of(waddr_i[p]) == b)) begin
            wgnt_mat[b][p] = 1'b1;
            found          = 1'b1;
          end
        end
        for (int unsigned j = 0; j < NrBankRdPorts; j++) begin
          found = 1'b0;
          for (int unsigned i = 0; i < NrReadPorts; i++) begin
            if (!found && ((i % NrBankRdPorts) == j) && re_i[i] && raged[i] &&
                (bank_of(raddr_i[i]) == b)) begin
              rgnt_mat[b][j][i] = 1'b1;
              found             = 1'b1;
            end
          end
          for (int unsigned i = 0; i < NrReadPorts; i++) begin
            if (!found && ((i % NrBankRdPorts) == j) && re_i[i] &&
                (bank_of(raddr_i[i]) == b)) begin
              rgnt_mat[b][j][i] = 1'b1;
              found             = 1'b1;
            end
          end
        end
      end
    end
  end

  // Grant collection and AND-OR steering of the winners into the banks.
  always_comb begin
    wgnt_o     = '0;
    rgnt_o     = '0;
    bank_we    = '0;
    bank_waddr = '0;
    bank_wdata = '0;
    bank_wbe   = '0;
    bank_re    = '0;
    bank_raddr = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      wgnt_o     = wgnt_o | wgnt_mat[b];
      bank_we[b] = |wgnt_mat[b];
      for (int unsigned p = 0; p < NrWritePorts; p++) begin
        if (wgnt_mat[b][p]) begin
          bank_waddr[b] = row_of(waddr_i[p]);
          bank_wdata[b] = wdata_i[p];
          bank_wbe[b]   = wbe_i[p];
        end
      end
      for (int unsigned j = 0; j < NrBankRdPorts; j++) begin
        rgnt_o        = rgnt_o | rgnt_mat[b][j];
        bank_re[b][j] = |rgnt_mat[b][j];
        for (int unsigned i = 0; i < NrReadPorts; i++) begin
          if (rgnt_mat[b][j][i]) bank_raddr[b][j] = row_of(raddr_i[i]);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NrReadPorts; i++)
      for (int unsigned b = 0; b < NrBanks; b++)
        rbank_oh[i][b] = (bank_of(raddr_i[i]) == b);
  end

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    spatz_vrf_bank #(
      .NrRows    (NrRows),
      .NrRdPorts (NrBankRdPorts),
      .DataWidth (DataWidth),
      .RowW      (RowW)
    ) u_bank (
      .clk   (clk_i),
      .rst   (rst_i),
      .we    (bank_we[b]),
      .waddr (bank_waddr[b]),
      .wdata (bank_wdata[b]),
      .wbe   (bank_wbe[b]),
      .re    (bank_re[b]),
      .raddr (bank_raddr[b]),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstall_q   <= '0;
      rstall_q   <= '0;
      rvalid_q   <= '0;
      rbank_oh_q <= '0;
      hold_q     <= '0;
    end else begin
      for (int unsigned p = 0; p < NrWritePorts; p++) begin
        if (we_i[p] && !wgnt_o[p]) begin
          if (!waged[p]) wstall_q[p] <= wstall_q[p] + StallW'(1);
        end else begin
          wstall_q[p] <= '0;
        end
      end
      for (int unsigned i = 0; i < NrReadPorts; i++) begin
        if (re_i[i] && !rgnt_o[i]) begin
          if (!raged[i]) rstall_q[i] <= rstall_q[i] + StallW'(1);
        end else begin
          rstall_q[i] <= '0;
        end
        if (rgnt_o[i]) rbank_oh_q[i] <= rbank_oh[i];
        // Capture the delivered word so rdata_o holds after rvalid drops,
        // even if another port of the group later reuses the bank port.
        if (rvalid_q[i]) hold_q[i] <= rdata_o[i];
      end
      rvalid_q <= rgnt_o;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NrReadPorts; i++) begin
      rdata_o[i] = hold_q[i];
      if (rvalid_q[i]) begin
        rdata_o[i] = '0;
        for (int unsigned b = 0; b < NrBanks; b++) begin
          if (rbank_oh_q[i][b]) rdata_o[i] = bank_rdata[b][i % NrBankRdPorts];
        end
      end
    end
  end

  assign rvalid_o = rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_spatz_vrf_banked.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spatz_vrf_banked
// Description : Directed self-checking bench for spatz_vrf_banked with
//               default parameters. Honors SPATZ_VRF_WBYPASS_EN for the
//               same-cycle read/write expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spatz_vrf_banked;

  localparam int NRP = 5;
  localparam int NWP = 3;
  localparam int AW  = 7;
  localparam int DW  = 256;
  localparam int BW  = DW / 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NWP-1:0][AW-1:0]   waddr;
  logic [NWP-1:0][DW-1:0]   wdata;
  logic [NWP-1:0][BW-1:0]   wbe;
  logic [NWP-1:0]           we;
  logic [NWP-1:0]           wgnt;
  logic [NRP-1:0][AW-1:0]   raddr;
  logic [NRP-1:0]           re;
  logic [NRP-1:0]           rgnt;
  logic [NRP-1:0][DW-1:0]   rdata;
  logic [NRP-1:0]           rvalid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spatz_vrf_banked dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .wbe_i    (wbe),
    .we_i     (we),
    .wgnt_o   (wgnt),
    .raddr_i  (raddr),
    .re_i     (re),
    .rgnt_o   (rgnt),
    .rdata_o  (rdata),
    .rvalid_o (rvalid)
  );

  task automatic idle();
    we = '0; re = '0; waddr = '0; wdata = '0; wbe = '0; raddr = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    re[0] = 1'b1; raddr[0] = 7'd7;
    we[0] = 1'b1; waddr[0] = 7'd7; wdata[0] = {32{8'hFF}}; wbe[0] = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rgnt !== 5'b0 || wgnt !== 3'b0)
        $display("FAIL reset_gnt: rgnt=%b wgnt=%b expected 0", rgnt, wgnt);
      if (rgnt !== 5'b0 || wgnt !== 3'b0) errors++;
      checks++;
      if (rvalid !== 5'b0 || rdata[0] !== '0) begin
        errors++;
        $display("FAIL reset_out: rvalid=%b rdata0=%h expected 0", rvalid, rdata[0]);
      end
      next();
    end
    rst = 1'b0;
    we  = '0;
    @(negedge clk);
    checks++;
    if (rgnt !== 5'b00001) begin
      errors++;
      $display("FAIL reset_first_gnt: rgnt=%b expected 00001", rgnt);
    end
    next();
    idle();
    @(negedge clk);
    checks++;
    if (rvalid !== 5'b00001 || rdata[0] !== '0) begin
      errors++;
      $display("FAIL reset_first_read: rvalid=%b rdata0=%h expected 00001/0", rvalid, rdata[0]);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] a5;
    a5 = {32{8'hA5}};
    next(); idle();
    we[0] = 1'b1; waddr[0] = 7'd5; wdata[0] = a5; wbe[0] = '1;
    @(negedge clk);
    checks++;
    if (wgnt !== 3'b001) begin
      errors++;
      $display("FAIL wr_gnt: wgnt=%b expected 001", wgnt);
    end
    next(); idle();
    re[0] = 1'b1; raddr[0] = 7'd5;
    @(negedge clk);
    checks++;
    if (rgnt !== 5'b00001) begin
      errors++;
      $display("FAIL rd_gnt: rgnt=%b expected 00001", rgnt);
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if (rvalid !== 5'b00001 || rdata[0] !== a5) begin
      errors++;
      $display("FAIL rd_data: rvalid=%b rdata0=%h expected 00001/%h", rvalid, rdata[0], a5);
    end
    next();
    @(negedge clk);
    checks++;
    if (rvalid !== 5'b0 || rdata[0] !== a5) begin
      errors++;
      $display("FAIL rd_hold: rvalid=%b rdata0=%h expected 0/%h", rvalid, rdata[0], a5);
    end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] exp;
    exp = {{28{8'hA5}}, {4{8'h3C}}};
    next(); idle();
    we[0] = 1'b1; waddr[0] = 7'd5; wdata[0] = {32{8'h3C}}; wbe[0] = 32'h0000000F;
    @(negedge clk);
    checks++;
    if (wgnt !== 3'b001) begin
      errors++;
      $display("FAIL be_wgnt: wgnt=%b expected 001", wgnt);
    end
    next(); idle();
    re[2] = 1'b1; raddr[2] = 7'd5;
    @(negedge clk);
    checks++;
    if (rgnt !== 5'b00100) begin
      errors++;
      $display("FAIL be_rgnt: rgnt=%b expected 00100", rgnt);
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if (rvalid !== 5'b00100 || rdata[2] !== exp) begin
      errors++;
      $display("FAIL be_data: rvalid=%b rdata2=%h expected 00100/%h", rvalid, rdata[2], exp);
    end
  endtask

  // Ports 0 and 3 share read group 0 and bank 1; port 1 (group 1) reads
  // bank 1 too but on its own bank port, so it is granted every cycle.
  task automatic test_aging();
    logic [NRP-1:0] exp, prev;
    logic [DW-1:0]  w5;
    w5   = {{28{8'hA5}}, {4{8'h3C}}};
    prev = '0;
    next(); idle();
    re[0] = 1'b1; raddr[0] = 7'd1;
    re[3] = 1'b1; raddr[3] = 7'd13;
    re[1] = 1'b1; raddr[1] = 7'd5;
    for (int c = 0; c < 10; c++) begin
      exp = (c == 4 || c == 9) ? 5'b01010 : 5'b00011;
      @(negedge clk);
      checks++;
      if (rgnt !== exp) begin
        errors++;
        $display("FAIL aging_gnt c%0d: rgnt=%b expected %b", c, rgnt, exp);
      end
      if (c > 0) begin
        checks++;
        if (rvalid !== prev || rdata[1] !== w5) begin
          errors++;
          $display("FAIL aging_valid c%0d: rvalid=%b rdata1=%h expected %b/%h", c, rvalid, rdata[1], prev, w5);
        end
      end
      prev = exp;
      next();
    end
    idle();
    @(negedge clk);
    checks++;
    if (rvalid !== 5'b01010 || rdata[3] !== '0) begin
      errors++;
      $display("FAIL aging_last: rvalid=%b rdata3=%h expected 01010/0", rvalid, rdata[3]);
    end
  endtask

  task automatic test_write_conflict();
    next(); idle();
    we[0] = 1'b1; waddr[0] = 7'd2; wdata[0] = {32{8'h22}}; wbe[0] = '1;
    we[1] = 1'b1; waddr[1] = 7'd6; wdata[1] = {32{8'h66}}; wbe[1] = '1;
    @(negedge clk);
    checks++;
    if (wgnt !== 3'b001) begin
      errors++;
      $display("FAIL wc_same_bank0: wgnt=%b expected 001", wgnt);
    end
    next();
    we[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (wgnt !== 3'b010) begin
      errors++;
      $display("FAIL wc_same_bank1: wgnt=%b expected 010", wgnt);
    end
    next(); idle();
    we[0] = 1'b1; waddr[0] = 7'd10; wdata[0] = {32{8'hAA}}; wbe[0] = '1;
    we[1] = 1'b1; waddr[1] = 7'd11; wdata[1] = {32{8'hBB}}; wbe[1] = '1;
    we[2] = 1'b1; waddr[2] = 7'd14; wdata[2] = {32{8'hEE}}; wbe[2] = '1;
    @(negedge clk);
    checks++;
    if (wgnt !== 3'b011) begin
      errors++;
      $display("FAIL wc_diff_bank: wgnt=%b expected 011", wgnt);
    end
    next();
    we[0] = 1'b0; we[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (wgnt !== 3'b100) begin
      errors++;
      $display("FAIL wc_port2: wgnt=%b expected 100", wgnt);
    end
    next(); idle();
    re[0] = 1'b1; raddr[0] = 7'd2;
    re[1] = 1'b1; raddr[1] = 7'd6;
    re[2] = 1'b1; raddr[2] = 7'd10;
    re[3] = 1'b1; raddr[3] = 7'd11;
    re[4] = 1'b1; raddr[4] = 7'd14;
    @(negedge clk);
    checks++;
    if (rgnt !== 5'b01111) begin
      errors++;
      $display("FAIL wc_rgnt: rgnt=%b expected 01111", rgnt);
    end
    next();
    re[3:0] = '0;
    @(negedge clk);
    checks++;
    if (rgnt !== 5'b10000 || rvalid !== 5'b01111) begin
      errors++;
      $display("FAIL wc_rgnt2: rgnt=%b rvalid=%b expected 10000/01111", rgnt, rvalid);
    end
    checks++;
    if (rdata[0] !== {32{8'h22}} || rdata[1] !== {32{8'h66}} ||
        rdata[2] !== {32{8'hAA}} || rdata[3] !== {32{8'hBB}}) begin
      errors++;
      $display("FAIL wc_data: rdata0=%h rdata1=%h rdata2=%h rdata3=%h expected 22../66../AA../BB..",
               rdata[0], rdata[1], rdata[2], rdata[3]);
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if (rvalid !== 5'b10000 || rdata[4] !== {32{8'hEE}}) begin
      errors++;
      $display("FAIL wc_data4: rvalid=%b rdata4=%h expected 10000/EE..", rvalid, rdata[4]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp;
`ifdef SPATZ_VRF_WBYPASS_EN
    exp = {32{8'hFF}};
`else
    exp = {32{8'h11}};
`endif
    next(); idle();
    we[0] = 1'b1; waddr[0] = 7'd9; wdata[0] = {32{8'h11}}; wbe[0] = '1;
    @(negedge clk);
    checks++;
    if (wgnt !== 3'b001) begin
      errors++;
      $display("FAIL byp_init: wgnt=%b expected 001", wgnt);
    end
    next(); idle();
    we[1] = 1'b1; waddr[1] = 7'd9; wdata[1] = {32{8'hFF}}; wbe[1] = '1;
    re[0] = 1'b1; raddr[0] = 7'd9;
    @(negedge clk);
    checks++;
    if (wgnt !== 3'b010 || rgnt !== 5'b00001) begin
      errors++;
      $display("FAIL byp_gnt: wgnt=%b rgnt=%b expected 010/00001", wgnt, rgnt);
    end
    next(); idle();
    re[0] = 1'b1; raddr[0] = 7'd9;
    @(negedge clk);
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== exp) begin
      errors++;
      $display("FAIL byp_same_cycle: rvalid0=%b rdata0=%h expected 1/%h", rvalid[0], rdata[0], exp);
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== {32{8'hFF}}) begin
      errors++;
      $display("FAIL byp_after: rvalid0=%b rdata0=%h expected 1/FF..", rvalid[0], rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] exps  [3];
    addrs[0] = 7'd2;  exps[0] = {32{8'h22}};
    addrs[1] = 7'd6;  exps[1] = {32{8'h66}};
    addrs[2] = 7'd10; exps[2] = {32{8'hAA}};
    next(); idle();
    re[4] = 1'b1; raddr[4] = addrs[0];
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (rgnt[4] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gnt k%0d: rgnt4=%b expected 1", k, rgnt[4]);
      end
      next();
      if (k < 3) raddr[4] = addrs[k];
      else       re[4] = 1'b0;
      @(negedge clk);
      checks++;
      if (rvalid[4] !== 1'b1 || rdata[4] !== exps[k-1]) begin
        errors++;
        $display("FAIL b2b_data k%0d: rvalid4=%b rdata4=%h expected 1/%h", k, rvalid[4], rdata[4], exps[k-1]);
      end
      if (k < 3) begin
        // re-align with the loop head, which expects to sit before negedge
        // of the cycle whose grant is checked; that is this same cycle.
        checks++;
        if (rgnt[4] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_cont k%0d: rgnt4=%b expected 1", k, rgnt[4]);
        end
        next();
        if (k + 1 < 3) raddr[4] = addrs[k+1];
        else           re[4] = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid[4] !== 1'b1 || rdata[4] !== exps[k]) begin
          errors++;
          $display("FAIL b2b_data2 k%0d: rvalid4=%b rdata4=%h expected 1/%h", k, rvalid[4], rdata[4], exps[k]);
        end
        break;
      end
    end
  endtask

  task automatic test_reset_midrun();
    next(); idle();
    re[0] = 1'b1; raddr[0] = 7'd9;
    @(negedge clk);
    checks++;
    if (rgnt !== 5'b00001) begin
      errors++;
      $display("FAIL mid_gnt: rgnt=%b expected 00001", rgnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if (rvalid !== 5'b0 || rdata[0] !== '0) begin
      errors++;
      $display("FAIL mid_rvalid: rvalid=%b rdata0=%h expected 0/0", rvalid, rdata[0]);
    end
    next();
    rst = 1'b0;
    re[0] = 1'b1; raddr[0] = 7'd9;
    @(negedge clk);
    checks++;
    if (rgnt !== 5'b00001) begin
      errors++;
      $display("FAIL mid_regnt: rgnt=%b expected 00001", rgnt);
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if (rvalid !== 5'b00001 || rdata[0] !== '0) begin
      errors++;
      $display("FAIL mid_cleared: rvalid=%b rdata0=%h expected 00001/0", rvalid, rdata[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_aging();
    test_write_conflict();
    test_bypass();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
